// File: rtl/mlp_seq_classifier_if.sv
// Config, input and result handshake bundle for mlp_seq_classifier.
// The master side is the sensor packer / result consumer; the classifier is the slave.
interface mlp_seq_classifier_if #(
    parameter int N_IN   = 8,
    parameter int IN_W   = 4,
    parameter int N_HID  = 3,
    parameter int N_OUT  = 3,
    parameter int BIAS_W = 16,
    parameter int ACC_W  = 20,
    parameter int CLS_W  = $clog2(N_OUT),
    parameter int ADDR_W = $clog2(N_HID*N_IN + N_HID + N_OUT*N_HID + N_OUT)
);
    logic                   cfg_we;
    logic [ADDR_W-1:0]      cfg_addr;
    logic [BIAS_W-1:0]      cfg_data;
    logic                   cfg_busy;
    logic                   in_valid;
    logic                   in_ready;
    logic [N_IN*IN_W-1:0]   inp;
    logic                   out_valid;
    logic                   out_ready;
    logic [CLS_W-1:0]       out_class;
    logic [ACC_W-1:0]       out_score;

    modport master (
        output cfg_we, cfg_addr, cfg_data, in_valid, inp, out_ready,
        input  cfg_busy, in_ready, out_valid, out_class, out_score
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, in_valid, inp, out_ready,
        output cfg_busy, in_ready, out_valid, out_class, out_score
    );
endinterface

// File: rtl/mlp_seq_classifier.sv
// Time-multiplexed 2-layer quantised MLP with running argmax, one shared signed MAC.
// Optional MLP_RELU_SAT_EN: hidden activations saturate instead of truncating to HID_W.
module mlp_seq_classifier #(
    parameter int N_IN   = 8,
    parameter int IN_W   = 4,
    parameter int N_HID  = 3,
    parameter int N_OUT  = 3,
    parameter int WGT_W  = 8,
    parameter int BIAS_W = 16,
    parameter int HID_W  = 12,
    parameter int ACC_W  = 20,
    parameter int CLS_W  = $clog2(N_OUT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mlp_seq_classifier_if.slave  bus
);
    localparam int L0B     = N_HID*N_IN;
    localparam int L1W     = L0B + N_HID;
    localparam int L1B     = L1W + N_OUT*N_HID;
    localparam int NWORDS  = L1B + N_OUT;
    localparam int ADDR_W  = $clog2(NWORDS);
    localparam int CNT_W   = $clog2(((N_IN > N_HID) ? N_IN : N_HID) + 1);
    localparam int NEU_W   = $clog2((N_HID > N_OUT) ? N_HID : N_OUT);
    localparam int HIDX_W  = $clog2(N_HID);
    localparam int INIDX_W = $clog2(N_IN);

    typedef enum logic [1:0] {S_IDLE, S_L0, S_L1, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [BIAS_W-1:0]         rf_q [NWORDS];
    logic [N_IN*IN_W-1:0]      inp_q;
    logic [IN_W-1:0]           in_arr [N_IN];
    logic [HID_W-1:0]          h_q [N_HID];
    logic [HID_W-1:0]          h_d [N_HID];
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [NEU_W-1:0]          neu_q, neu_d;
    logic [CNT_W-1:0]          idx_q, idx_d;
    logic [ACC_W-1:0]          best_q, best_d;
    logic [CLS_W-1:0]          cls_q, cls_d;
    logic                      out_valid_q, out_valid_d;
    logic [CLS_W-1:0]          out_class_q, out_class_d;
    logic [ACC_W-1:0]          out_score_q, out_score_d;
    logic                      accept, cfg_wr;
    logic signed [ACC_W-1:0]   mac_x, mac_w, mac_b;
    logic [ACC_W-1:0]          score;
    logic [ADDR_W-1:0]         l0_addr, l0b_addr, l1_addr, l1b_addr;

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_unpack
        assign in_arr[gi] = inp_q[gi*IN_W +: IN_W];
    end

    function automatic logic signed [ACC_W-1:0] wsext(input logic [BIAS_W-1:0] v);
        return {{(ACC_W-WGT_W){v[WGT_W-1]}}, v[WGT_W-1:0]};
    endfunction

    function automatic logic signed [ACC_W-1:0] bsext(input logic [BIAS_W-1:0] v);
        return {{(ACC_W-BIAS_W){v[BIAS_W-1]}}, v};
    endfunction

    function automatic logic [ACC_W-1:0] relu(input logic [ACC_W-1:0] a);
        return a[ACC_W-1] ? '0 : a;
    endfunction

    function automatic logic [HID_W-1:0] hid_reduce(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] r;
        r = relu(a);
`ifdef MLP_RELU_SAT_EN
        return (|r[ACC_W-1:HID_W]) ? '1 : r[HID_W-1:0];
`else
        return HID_W'(r);
`endif
    endfunction

    assign l0_addr  = ADDR_W'(int'(neu_q)*N_IN + int'(idx_q));
    assign l0b_addr = ADDR_W'(L0B + int'(neu_q));
    assign l1_addr  = ADDR_W'(L1W + int'(neu_q)*N_HID + int'(idx_q));
    assign l1b_addr = ADDR_W'(L1B + int'(neu_q));
    assign score    = relu(acc_q);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        neu_d       = neu_q;
        idx_d       = idx_q;
        best_d      = best_q;
        cls_d       = cls_q;
        h_d         = h_q;
        out_valid_d = out_valid_q;
        out_class_d = out_class_q;
        out_score_d = out_score_q;
        accept      = 1'b0;
        cfg_wr      = 1'b0;
        mac_x       = '0;
        mac_w       = '0;
        mac_b       = acc_q;
        case (state_q)
            S_IDLE: begin
                cfg_wr = bus.cfg_we && (int'(bus.cfg_addr) < NWORDS);
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = S_L0;
                    neu_d   = '0;
                    idx_d   = '0;
                end
            end
            S_L0: begin
                if (idx_q < CNT_W'(N_IN)) begin
                    // Bias folds into the first MAC so no separate preload cycle is needed.
                    mac_x = ACC_W'(in_arr[idx_q[INIDX_W-1:0]]);
                    mac_w = wsext(rf_q[l0_addr]);
                    mac_b = (idx_q == '0) ? bsext(rf_q[l0b_addr]) : acc_q;
                    acc_d = mac_b + mac_x * mac_w;
                    idx_d = idx_q + CNT_W'(1);
                end else begin
                    h_d[neu_q[HIDX_W-1:0]] = hid_reduce(acc_q);
                    idx_d = '0;
                    if (neu_q == NEU_W'(N_HID-1)) begin
                        neu_d   = '0;
                        state_d = S_L1;
                    end else begin
                        neu_d = neu_q + NEU_W'(1);
                    end
                end
            end
            S_L1: begin
                if (idx_q < CNT_W'(N_HID)) begin
                    mac_x = ACC_W'(h_q[idx_q[HIDX_W-1:0]]);
                    mac_w = wsext(rf_q[l1_addr]);
                    mac_b = (idx_q == '0) ? bsext(rf_q[l1b_addr]) : acc_q;
                    acc_d = mac_b + mac_x * mac_w;
                    idx_d = idx_q + CNT_W'(1);
                end else begin
                    // Strict compare keeps the lower index on ties.
                    if (neu_q == '0 || score > best_q) begin
                        best_d = score;
                        cls_d  = CLS_W'(neu_q);
                    end
                    idx_d = '0;
                    if (neu_q == NEU_W'(N_OUT-1)) begin
                        neu_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        neu_d = neu_q + NEU_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_class_d = cls_q;
                    out_score_d = best_q;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NWORDS; k++) rf_q[k] <= '0;
            for (int k = 0; k < N_HID; k++) h_q[k] <= '0;
            inp_q       <= '0;
            acc_q       <= '0;
            neu_q       <= '0;
            idx_q       <= '0;
            best_q      <= '0;
            cls_q       <= '0;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            out_score_q <= '0;
        end else begin
            if (cfg_wr) rf_q[bus.cfg_addr] <= bus.cfg_data;
            if (accept) inp_q <= bus.inp;
            h_q         <= h_d;
            acc_q       <= acc_d;
            neu_q       <= neu_d;
            idx_q       <= idx_d;
            best_q      <= best_d;
            cls_q       <= cls_d;
            out_valid_q <= out_valid_d;
            out_class_q <= out_class_d;
            out_score_q <= out_score_d;
        end
    end

    assign bus.cfg_busy  = (state_q != S_IDLE);
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_class = out_class_q;
    assign bus.out_score = out_score_q;
endmodule
